// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared types and helpers for the nn_mac_array slice.
//   nn_state_e   : controller state (IDLE / ACCUM / OUTPUT)
//   idx_w()      : clog2-derived select width, never narrower than 1 bit
//   sat_to_width : clamp a wide signed value into a signed w-bit range
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } nn_state_e;

    // Working width of the saturation helper; callers sign-extend into it.
    localparam int SAT_W = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_to_width(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = {{(SAT_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/nn_mac_array_pp.sv
// -----------------------------------------------------------------------------
// nn_neuron_pp
// Post-processing of one neuron's accumulator into a DATA_W result:
// bias add, arithmetic right shift (floor), optional ReLU, saturation.
// Purely combinational; the array instantiates one copy and steers the
// selected neuron into it.
//   acc, bias : signed ACC_W accumulator and bias
//   shift     : right-shift amount
//   relu_en   : clamp negative results to zero
//   result    : signed DATA_W saturated result
// -----------------------------------------------------------------------------
module nn_neuron_pp
    import nn_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 20,
    parameter int SHIFT_W = 5
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                     relu_en,
    output logic signed [DATA_W-1:0] result
);

    // One extra bit so acc+bias can never wrap before saturation.
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;
    logic signed [ACC_W:0] rect;

    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
        shifted = sum >>> shift;
        rect    = (relu_en && shifted < 0) ? '0 : shifted;
        result  = DATA_W'(sat_to_width(SAT_W'(rect), DATA_W));
    end

endmodule

// File: rtl/nn_mac_array.sv
// -----------------------------------------------------------------------------
// nn_mac_array
// NUM_NEURONS parallel multiply-accumulate neurons sharing one input stream.
// Each accepted input sample is multiplied by every neuron's weight for the
// current position and accumulated; at vector end the per-neuron results
// (bias, shift, ReLU, saturate) are emitted one neuron per handshake.
//   clk, rst                  : clock, synchronous active-high reset
//   cfg_we/cfg_bias/cfg_neuron/cfg_index/cfg_data : weight/bias write port
//   relu_en, shift            : output post-processing, captured at vector end
//   in_valid/in_ready/in_data/in_last : input sample stream
//   out_valid/out_ready/out_data/out_idx : per-neuron result stream
//   busy                      : a vector is being accumulated or emitted
// -----------------------------------------------------------------------------
module nn_mac_array
    import nn_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 20,
    parameter int NUM_NEURONS = 4,
    parameter int MAX_INPUTS  = 16,
    localparam int NIDX_W     = idx_w(NUM_NEURONS),
    localparam int CNT_W      = idx_w(MAX_INPUTS),
    localparam int SHIFT_W    = idx_w(ACC_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic                     cfg_bias,
    input  logic        [NIDX_W-1:0] cfg_neuron,
    input  logic        [CNT_W-1:0]  cfg_index,
    input  logic signed [ACC_W-1:0]  cfg_data,
    input  logic                     relu_en,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic        [NIDX_W-1:0] out_idx,
    output logic                     busy
);

    nn_state_e state, state_nx;

    logic signed [DATA_W-1:0]   weight   [NUM_NEURONS][MAX_INPUTS];
    logic signed [ACC_W-1:0]    bias     [NUM_NEURONS];
    // Bias captured at vector start so an IDLE write landing on the first
    // beat only affects the following vector.
    logic signed [ACC_W-1:0]    bias_vec [NUM_NEURONS];
    logic signed [ACC_W-1:0]    acc      [NUM_NEURONS];
    logic signed [2*DATA_W-1:0] prod     [NUM_NEURONS];
    logic        [CNT_W-1:0]    count;
    logic        [CNT_W-1:0]    wsel;
    logic        [SHIFT_W-1:0]  shift_q;
    logic                       relu_q;

    logic first_beat;
    logic accept;
    logic last_beat;
    logic out_fire;
    logic final_fire;

    // in_ready is a function of state only, never of in_valid.
    assign first_beat = (state == ST_IDLE);
    assign accept     = in_valid && (state != ST_OUTPUT);
    // The beat at position MAX_INPUTS-1 closes the vector regardless of in_last.
    assign last_beat  = in_last ||
                        (first_beat ? (MAX_INPUTS == 1) : (count == CNT_W'(MAX_INPUTS - 1)));
    assign out_fire   = (state == ST_OUTPUT) && out_ready;
    assign final_fire = out_fire && (out_idx == NIDX_W'(NUM_NEURONS - 1));
    assign wsel       = first_beat ? '0 : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = last_beat ? ST_OUTPUT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                busy = 1'b1;
                if (accept && last_beat) begin
                    state_nx = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                busy      = 1'b1;
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (final_fire) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            prod[n] = weight[n][wsel] * in_data;
        end
    end

    // ---- accumulate stage: config writes, MAC, output index ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                acc[n]      <= '0;
                bias[n]     <= '0;
                bias_vec[n] <= '0;
                for (int k = 0; k < MAX_INPUTS; k++) begin
                    weight[n][k] <= '0;
                end
            end
            count   <= '0;
            out_idx <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else begin
            if (first_beat && cfg_we) begin
                if (cfg_bias) begin
                    bias[cfg_neuron] <= cfg_data;
                end else begin
                    weight[cfg_neuron][cfg_index] <= cfg_data[DATA_W-1:0];
                end
            end
            if (accept) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    if (first_beat) begin
                        acc[n]      <= ACC_W'(prod[n]);
                        bias_vec[n] <= bias[n];
                    end else begin
                        acc[n] <= acc[n] + ACC_W'(prod[n]);
                    end
                end
                count <= first_beat ? CNT_W'(1) : count + CNT_W'(1);
                if (last_beat) begin
                    shift_q <= shift;
                    relu_q  <= relu_en;
                end
            end
            if (out_fire) begin
                out_idx <= final_fire ? '0 : out_idx + NIDX_W'(1);
            end
        end
    end

    // ---- output stage: selected neuron through the shared post-processor ----
    nn_neuron_pp #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_pp (
        .acc     (acc[out_idx]),
        .bias    (bias_vec[out_idx]),
        .shift   (shift_q),
        .relu_en (relu_q),
        .result  (out_data)
    );

endmodule

// File: doc/nn_mac_array.md
NN_MAC_ARRAY -- requirements
Module: nn_mac_array

Interface
REQ-001 Parameter DATA_W, default 8: signed activation/weight/output width.
REQ-002 Parameter ACC_W, default 20: signed accumulator width; ACC_W SHALL be >= 2*DATA_W+clog2(MAX_INPUTS).
REQ-003 Parameter NUM_NEURONS, default 4: neurons evaluated in parallel.
REQ-004 Parameter MAX_INPUTS, default 16: maximum input vector length.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_we  in  1  write strobe for a weight or bias.
REQ-008 cfg_bias  in  1  1 = write bias of cfg_neuron; 0 = write weight[cfg_neuron][cfg_index].
REQ-009 cfg_neuron  in  clog2(NUM_NEURONS)  neuron select.
REQ-010 cfg_index  in  clog2(MAX_INPUTS)  input index select.
REQ-011 cfg_data  in  ACC_W  signed write data; weights take the low DATA_W bits, biases the full ACC_W.
REQ-012 relu_en  in  1  enables ReLU on outputs; sampled when OUTPUT is entered.
REQ-013 shift  in  clog2(ACC_W)  arithmetic right-shift amount; sampled when OUTPUT is entered.
REQ-014 in_valid / in_ready  in / out  1 each  input-sample handshake.
REQ-015 in_data  in  DATA_W  signed input sample.
REQ-016 in_last  in  1  marks the final sample of a vector.
REQ-017 out_valid / out_ready  out / in  1 each  result handshake.
REQ-018 out_data  out  DATA_W  signed neuron result.
REQ-019 out_idx  out  clog2(NUM_NEURONS)  index of the neuron whose result is on out_data.
REQ-020 busy  out  1  high in ACCUM and OUTPUT.

Function
REQ-021 FSM states: IDLE, ACCUM, OUTPUT.
REQ-022 IDLE: in_ready=1; an accepted beat starts a vector: every accumulator is loaded with weight[n][0]*in_data; sample count set to 1; next state ACCUM, or OUTPUT if in_last.
REQ-023 ACCUM: in_ready=1; accepted beat k adds weight[n][k]*in_data to acc[n] for all n in the same cycle; full-precision signed product.
REQ-024 Vector end: beat with in_last=1, or beat with count = MAX_INPUTS-1 (forced last, in_last ignored); next state OUTPUT.
REQ-025 OUTPUT: in_ready=0; out_valid=1 from the first cycle after the last beat; neurons are emitted in order 0..NUM_NEURONS-1, one per out_valid&&out_ready cycle.
REQ-026 Result per neuron: r = (acc+bias) >>> shift (arithmetic, floor); if relu_en and r<0 then r=0; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 While out_valid=1 and out_ready=0, out_data and out_idx SHALL hold stable.
REQ-028 Handshake with out_idx = NUM_NEURONS-1 returns to IDLE; out_valid=0 next cycle.
REQ-029 cfg_we honoured only in IDLE; writes in ACCUM/OUTPUT are dropped; cfg_we together with an input beat in IDLE: write takes effect for the next vector, not the current one.
REQ-030 out_valid never depends combinationally on out_ready; in_ready never depends on in_valid.

Reset
REQ-031 rst SHALL force IDLE, out_valid=0, out_data=0, out_idx=0, busy=0, in_ready=1 the cycle after assertion.
REQ-032 rst SHALL clear all accumulators, sample count, weights and biases to 0, including mid-vector or mid-output.

Structure
REQ-033 Shared package nn_pkg holds the FSM state enum and helper functions sat_to_width and clog2-derived width constants.
REQ-034 One sub-module nn_neuron_pp (bias add, shift, ReLU, saturate) is instantiated once, multiplexed by out_idx.

Verification
REQ-035 Reset: assert rst 2 cycles -> out_valid=0, busy=0, in_ready=1, all readback results 0.
REQ-036 All weights 1, bias 0, shift 0, inputs 1,2,3,4 (last on 4) -> outputs 10 for idx 0..3, out_valid one cycle after beat 4.
REQ-037 Weights 127, inputs 127 x4 -> 127 (saturated); weights -128 same inputs, relu_en=0 -> -128; relu_en=1 -> 0.
REQ-038 Bias 64, inputs zero, shift 2 -> 16; bias -5, shift 1 -> -3.
REQ-039 Hold out_ready=0 for 5 cycles in OUTPUT -> out_data/out_idx stable, in_ready=0, cfg writes ignored.
REQ-040 16 beats without in_last (MAX_INPUTS=16) -> OUTPUT entered after 16th; rst asserted during beat 8 of another vector -> IDLE, next vector with unwritten weights yields 0.
